// File: rtl/axi_lite_mem_responder.sv
// axi_lite_mem_responder
//   Memory responder at the far end of the cache memory bus. Serves the
//   five-channel lite bus (write address, write data, write response, read
//   address, read data) from an internal word-addressed RAM. One address per
//   beat; reads are queued in order and answered after RD_LATENCY cycles.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   waaddr/wavalid/waready     write address channel
//   wdata/wvalid/wready        write data channel
//   bresp/bvalid/bready        write response (00 OKAY, 10 SLVERR)
//   raaddr/ravalid/raready     read address channel
//   rdata/rvalid/rready        read data channel
//
// Optional build macro
//   RAND_STALL_EN  pseudo-random wait states on the ready outputs and on rvalid,
//                  driven by a 16-bit LFSR, to exercise initiator stall handling.
module axi_lite_mem_responder #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                MEM_AW     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                RD_LATENCY = 2,
    parameter int                RQ_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] waaddr,
    input  logic              wavalid,
    output logic              waready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] raaddr,
    input  logic              ravalid,
    output logic              raready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready
);

    localparam int                PTR_W     = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int                CNT_W     = $clog2(RQ_DEPTH + 1);
    localparam int                MEM_WORDS = 1 << MEM_AW;
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS) << 2;
    localparam logic [3:0]        CD_INIT   = 4'(RD_LATENCY - 1);
    localparam logic [1:0]        RESP_OKAY = 2'b00;
    localparam logic [1:0]        RESP_SLV  = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [3:0]        cd;     // cycles left before this entry may be presented
    } rq_entry_t;

    // Unsigned offset compare also rejects addresses below BASE_ADDR (they wrap high).
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a - BASE_ADDR) < MEM_BYTES;
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return MEM_AW'((a - BASE_ADDR) >> 2);
    endfunction

    // ------------------------------------------------------------------
    // Wait-state gating: bit0 waready, bit1 wready, bit2 raready, bit3 rvalid
    // ------------------------------------------------------------------
    logic [3:0] gate;

`ifdef RAND_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign gate = lfsr[3:0];
`else
    assign gate = 4'hF;
`endif

    // ------------------------------------------------------------------
    // RAM (contents not reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Write path: independent 1-entry holders for address and data
    // ------------------------------------------------------------------
    logic              aw_full, w_full;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_buf;
    logic              aw_hs, w_hs, commit;

    assign waready = !aw_full & gate[0];
    assign wready  = !w_full  & gate[1];
    assign aw_hs   = wavalid & waready;
    assign w_hs    = wvalid  & wready;
    // Commit only once the previous response has been taken (or is being taken now).
    assign commit  = aw_full & w_full & (!bvalid | bready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_buf   <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            // A handshake needs an empty holder and commit needs both full,
            // so loads and the commit clear never collide.
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= waaddr;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_buf  <= wdata;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= in_range(aw_addr) ? RESP_OKAY : RESP_SLV;
            end else if (bready) begin
                bvalid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && in_range(aw_addr)) mem[word_idx(aw_addr)] <= w_buf;
    end

    // ------------------------------------------------------------------
    // Read path: in-order queue; data captured at acceptance, so a read on
    // the same edge as a commit to that word returns the old contents.
    // ------------------------------------------------------------------
    rq_entry_t         rq [RQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              rd_push, rd_pop;
    logic [DATA_W-1:0] rd_data_in;
    rq_entry_t         head;

    assign head       = rq[rd_ptr];
    // Uses registered count only: a pop this cycle does not open a slot early.
    assign raready    = (count != CNT_W'(RQ_DEPTH)) & gate[2];
    assign rd_push    = ravalid & raready;
    assign rvalid     = (count != '0) & (head.cd == 4'd0) & gate[3];
    assign rdata      = rvalid ? head.data : '0;
    assign rd_pop     = rvalid & rready;
    assign rd_data_in = in_range(raaddr) ? mem[word_idx(raaddr)] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RQ_DEPTH; i++) rq[i] <= '0;
        end else begin
            // Saturating countdown; a gated head simply sits at zero.
            for (int i = 0; i < RQ_DEPTH; i++) begin
                if (rq[i].cd != 4'd0) rq[i].cd <= rq[i].cd - 4'd1;
            end
            if (rd_push) begin
                rq[wr_ptr] <= '{data: rd_data_in, cd: CD_INIT};
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (rd_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({rd_push, rd_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
module tb_axi_lite_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] waaddr = '0;
    logic        wavalid = 1'b0;
    logic        waready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] raaddr = '0;
    logic        ravalid = 1'b0;
    logic        raready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int errors = 0;

    axi_lite_mem_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .waaddr  (waaddr),
        .wavalid (wavalid),
        .waready (waready),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .raaddr  (raaddr),
        .ravalid (ravalid),
        .raready (raready),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single write with AW and W together; assumes bready=1 and bvalid=0 on entry.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] exp_resp);
        waaddr = a; wdata = d; wavalid = 1'b1; wvalid = 1'b1;
        tick();
        wavalid = 1'b0; wvalid = 1'b0;
        chk({tag, "_bvalid_early"}, 32'(bvalid), 32'd0);
        tick();
        chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        tick();
    endtask

    // Single read; assumes empty queue and rready=1.
    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        raaddr = a; ravalid = 1'b1;
        tick();
        ravalid = 1'b0;
        chk({tag, "_rvalid_early"}, 32'(rvalid), 32'd0);
        tick();
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rdata"}, rdata, exp);
        tick();
    endtask

    initial begin
        // ---- reset values ----
        tick();
        chk("rst_waready", 32'(waready), 32'd1);
        chk("rst_wready",  32'(wready),  32'd1);
        chk("rst_raready", 32'(raready), 32'd1);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        rst_n = 1'b1;
        bready = 1'b1;
        rready = 1'b1;
        tick();

        // ---- write/read same cycle AW+W ----
        do_write("wr10", 32'h8000_0010, 32'h1234_5678, 2'b00);
        do_read("rd10", 32'h8000_0010, 32'h1234_5678);

        // ---- W first, AW five edges later ----
        wdata = 32'hCAFE_F00D; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("w_first_wready0", 32'(wready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("w_wait_wready", 32'(wready), 32'd0);
            chk("w_wait_bvalid", 32'(bvalid), 32'd0);
        end
        waaddr = 32'h8000_0000; wavalid = 1'b1;
        tick();
        wavalid = 1'b0;
        chk("aw_late_wready", 32'(wready),  32'd0);
        chk("aw_late_waready", 32'(waready), 32'd0);
        chk("aw_late_bvalid", 32'(bvalid),  32'd0);
        tick();
        chk("late_commit_bvalid", 32'(bvalid),  32'd1);
        chk("late_commit_bresp",  32'(bresp),   32'd0);
        chk("late_commit_wready", 32'(wready),  32'd1);
        chk("late_commit_waready", 32'(waready), 32'd1);
        tick();
        chk("late_bvalid_clear", 32'(bvalid), 32'd0);
        do_read("rd00", 32'h8000_0000, 32'hCAFE_F00D);

        // ---- back-to-back reads of words 64..67 ----
        for (int i = 0; i < 4; i++)
            do_write("wr_line", 32'h8000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b00);
        for (int i = 0; i < 4; i++) begin
            raaddr = 32'h8000_0100 + 32'(4 * i); ravalid = 1'b1;
            tick();
            chk("b2b_raready", 32'(raready), 32'd1);
            if (i > 0) begin
                chk("b2b_rvalid", 32'(rvalid), 32'd1);
                chk("b2b_rdata",  rdata, 32'hA000_0000 + 32'(i - 1));
            end
        end
        ravalid = 1'b0;
        tick();
        chk("b2b_last_rvalid", 32'(rvalid), 32'd1);
        chk("b2b_last_rdata",  rdata, 32'hA000_0003);
        tick();
        chk("b2b_drained", 32'(rvalid), 32'd0);

        // ---- queue full backpressure ----
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            raaddr = 32'h8000_0100 + 32'(4 * i); ravalid = 1'b1;
            tick();
            chk("fill_raready", 32'(raready), (i < 3) ? 32'd1 : 32'd0);
        end
        raaddr = 32'h8000_0010;
        tick();
        chk("full_raready", 32'(raready), 32'd0);
        chk("full_rvalid",  32'(rvalid),  32'd1);
        chk("full_head",    rdata, 32'hA000_0000);
        rready = 1'b1;
        tick();
        chk("pop_raready", 32'(raready), 32'd1);
        chk("pop_rdata1",  rdata, 32'hA000_0001);
        tick();
        ravalid = 1'b0;
        chk("pop_rdata2", rdata, 32'hA000_0002);
        tick();
        chk("pop_rdata3", rdata, 32'hA000_0003);
        tick();
        chk("pop_rdata5", rdata, 32'h1234_5678);
        tick();
        chk("pop_empty", 32'(rvalid), 32'd0);

        // ---- out-of-range and range boundaries ----
        do_write("wr_oor0", 32'h0000_0000, 32'hDEAD_BEEF, 2'b10);
        do_read("rd_unchanged", 32'h8000_0000, 32'hCAFE_F00D);
        do_read("rd_oor0", 32'h0000_0000, 32'h0);
        do_write("wr_top", 32'h8000_0FFC, 32'h0F0F_0F0F, 2'b00);
        do_write("wr_past", 32'h8000_1000, 32'h1111_1111, 2'b10);
        do_write("wr_below", 32'h7FFF_FFFC, 32'h2222_2222, 2'b10);
        do_read("rd_top", 32'h8000_0FFC, 32'h0F0F_0F0F);
        do_read("rd_past", 32'h8000_1000, 32'h0);

        // ---- read accepted on the commit edge sees old data ----
        waaddr = 32'h8000_0010; wdata = 32'h55AA_55AA; wavalid = 1'b1; wvalid = 1'b1;
        tick();
        wavalid = 1'b0; wvalid = 1'b0;
        raaddr = 32'h8000_0010; ravalid = 1'b1;
        tick();
        ravalid = 1'b0;
        chk("haz_bvalid", 32'(bvalid), 32'd1);
        tick();
        chk("haz_rvalid", 32'(rvalid), 32'd1);
        chk("haz_old",    rdata, 32'h1234_5678);
        tick();
        do_read("haz_new", 32'h8000_0010, 32'h55AA_55AA);

        // ---- response hold and commit on the bready edge ----
        bready = 1'b0;
        waaddr = 32'h8000_0020; wdata = 32'h1; wavalid = 1'b1; wvalid = 1'b1;
        tick();
        wavalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("hold_bvalid", 32'(bvalid), 32'd1);
        tick();
        chk("hold_bvalid2", 32'(bvalid), 32'd1);
        waaddr = 32'h0000_0000; wdata = 32'h2; wavalid = 1'b1; wvalid = 1'b1;
        tick();
        wavalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("stall_bresp",   32'(bresp),   32'd0);
        chk("stall_waready", 32'(waready), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b2b_resp_bvalid", 32'(bvalid), 32'd1);
        chk("b2b_resp_bresp",  32'(bresp),  32'd2);
        tick();
        chk("b2b_resp_hold", 32'(bvalid), 32'd1);

        // ---- asynchronous reset mid-burst ----
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            raaddr = 32'h8000_0100 + 32'(4 * i); ravalid = 1'b1;
            tick();
        end
        ravalid = 1'b0;
        tick();
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", 32'(rvalid), 32'd0);
        chk("async_rst_bvalid", 32'(bvalid), 32'd0);
        chk("async_rst_rdata",  rdata,       32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_waready", 32'(waready), 32'd1);
        chk("post_rst_wready",  32'(wready),  32'd1);
        chk("post_rst_raready", 32'(raready), 32'd1);
        chk("post_rst_rvalid",  32'(rvalid),  32'd0);
        chk("post_rst_bvalid",  32'(bvalid),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
